// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: takes host words and shifts them LSB-first into the chain.
// Optional CRC-16-CCITT over the shifted stream when CONFIG_CHAIN_LOADER_CRC_EN is defined.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024,
  parameter int COUNT_WIDTH  = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WORD_WIDTH-1:0]  data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic                   config_data,
  output logic                   config_enable,
  output logic                   busy,
  output logic                   config_done,
  output logic [COUNT_WIDTH-1:0] bits_remaining
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  ,
  output logic [15:0]            crc
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [IW-1:0]          LAST_IDX = IW'(WORD_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [COUNT_WIDTH-1:0] ONE_CNT  = COUNT_WIDTH'(1);

  logic [1:0]             r_state;
  logic [WORD_WIDTH-1:0]  r_shift;
  logic [IW-1:0]          r_bit_idx;
  logic [COUNT_WIDTH-1:0] r_bits_rem;

  logic w_start_ok;
  logic w_accept;

  // start is only honoured from IDLE/DONE; abort beats everything
  assign w_start_ok = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !abort;
  assign w_accept   = (r_state == S_LOAD) && data_valid && !abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_bits_rem <= '0;
    end else if (abort) begin
      r_state    <= S_IDLE;
      r_bits_rem <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state    <= S_LOAD;
            r_bits_rem <= FULL_CNT;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_shift   <= data_in;
            r_bit_idx <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift    <= r_shift >> 1;
          r_bit_idx  <= r_bit_idx + 1'b1;
          r_bits_rem <= r_bits_rem - 1'b1;
          // a short final word ends here, leaving its upper bits unshifted
          if (r_bits_rem == ONE_CNT)
            r_state <= S_DONE;
          else if (r_bit_idx == LAST_IDX)
            r_state <= S_LOAD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_ready     = (r_state == S_LOAD);
  assign config_enable  = (r_state == S_SHIFT);
  assign config_data    = (r_state == S_SHIFT) && r_shift[0];
  assign busy           = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign config_done    = (r_state == S_DONE);
  assign bits_remaining = r_bits_rem;

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ r_shift[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_crc <= 16'hFFFF;
    else if (abort || w_start_ok)
      r_crc <= 16'hFFFF;
    else if (r_state == S_SHIFT)
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
  end

  assign crc = r_crc;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized scoreboard bench for config_chain_loader: a driver queues the expected chain bit
// stream per accepted word, a monitor pops and compares every shifted bit.
module tb_config_chain_loader;
  localparam int WW = 8;
  localparam int CL = 20;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, config_data, config_enable, busy, config_done;
  logic [CW-1:0] bits_remaining;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  logic [15:0]   crc;
`endif

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .config_data(config_data), .config_enable(config_enable), .busy(busy),
    .config_done(config_done), .bits_remaining(bits_remaining)
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    , .crc(crc)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int n_shift = 0;
  logic          exp_q[$];
  logic [WW-1:0] words_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return (c << 1) ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // scoreboard monitor: every shifted bit must be the next bit of the expected stream
  always @(negedge clock) begin
    if (!reset && config_enable) begin
      n_shift++;
      if (exp_q.size() == 0)
        chk("extra_shift", 1, 0);
      else
        chk("config_data", config_data, exp_q.pop_front());
    end
  end

  task automatic do_load(input int min_gap, input int max_gap, input bit poke_start);
    int rem, n, gap, cnt, s0;
    logic [WW-1:0] w;
    logic [15:0] crcm;
    s0 = n_shift;
    start = 1'b1; tick(); start = 1'b0;
    rem = CL; crcm = 16'hFFFF;
    chk("load_ready", data_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_done_clr", config_done, 0);
    while (rem > 0) begin
      w = (words_q.size() > 0) ? words_q.pop_front() : WW'($urandom());
      gap = $urandom_range(max_gap, min_gap);
      if (gap > 0) begin
        data_valid = 1'b0;
        repeat (gap) begin
          tick();
          chk("bp_ready", data_ready, 1);
          chk("bp_enable", config_enable, 0);
          chk("bp_remaining", bits_remaining, rem);
        end
      end
      chk("hs_remaining", bits_remaining, rem);
      data_in = w; data_valid = 1'b1; tick();
      n = (rem < WW) ? rem : WW;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(w[i]);
        crcm = crc_step(crcm, w[i]);
      end
      rem -= n;
      cnt = 0;
      if (poke_start) begin
        start = 1'b1; tick(); start = 1'b0; cnt = 1;
      end
      while (!data_ready && !config_done && cnt < WW + 4) begin
        tick(); cnt++;
      end
      chk("burst_len", cnt, n);
      if (rem > 0) chk("reload_ready", data_ready, 1);
      else         chk("done_set", config_done, 1);
    end
    chk("stream_drained", exp_q.size(), 0);
    chk("total_shifts", n_shift - s0, CL);
    chk("done_busy", busy, 0);
    chk("done_remaining", bits_remaining, 0);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    chk("crc", crc, crcm);
`endif
    repeat (2) tick();
    chk("done_no_ready", data_ready, 0);
    chk("done_no_enable", config_enable, 0);
    chk("done_hold", config_done, 1);
    data_valid = 1'b0;
  endtask

  task automatic start_first_word();
    logic [WW-1:0] w;
    start = 1'b1; tick(); start = 1'b0;
    w = WW'($urandom());
    data_in = w; data_valid = 1'b1; tick(); data_valid = 1'b0;
    for (int i = 0; i < WW; i++) exp_q.push_back(w[i]);
  endtask

  initial begin
    #3;
    chk("rst_ready", data_ready, 0);
    chk("rst_enable", config_enable, 0);
    chk("rst_data", config_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", config_done, 0);
    chk("rst_remaining", bits_remaining, 0);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    chk("rst_crc", crc, 16'hFFFF);
`endif
    tick(); reset = 1'b0; tick();

    // directed: 0xA5, 0x3C, 0x0F with continuous valid
    words_q = '{8'hA5, 8'h3C, 8'h0F};
    do_load(0, 0, 1'b0);

    repeat (4) do_load(0, 3, 1'b0);
    do_load(5, 5, 1'b0);
    do_load(0, 2, 1'b1);

    // abort after 5 shifted bits, start in the same cycle
    start_first_word();
    repeat (5) tick();
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", config_done, 0);
    chk("abort_enable", config_enable, 0);
    chk("abort_remaining", bits_remaining, 0);
    chk("abort_ready", data_ready, 0);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    chk("abort_crc", crc, 16'hFFFF);
`endif
    tick();
    chk("abort_idle", busy, 0);
    do_load(0, 1, 1'b0);

    // asynchronous reset between edges in the middle of a shift burst
    start_first_word();
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_enable", config_enable, 0);
    chk("arst_data", config_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_remaining", bits_remaining, 0);
    chk("arst_ready", data_ready, 0);
    tick(); reset = 1'b0;
    repeat (3) begin
      tick();
      chk("arst_no_shift", config_enable, 0);
    end
    do_load(0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
